// File: rtl/serial_cascade_comp.sv
// serial_cascade_comp: multi-cycle magnitude comparator for wide operands.
// Walks the captured operands MSB-chunk first, CHUNK bits per clock, and stops
// at the first unequal chunk. Emits a one-hot L/E/G triple (cascade source for
// a downstream comparator's aL/aE/aG inputs) together with a one-cycle done.
// Optional build macro: SERCMP_SIGNED_EN -- treats operands as two's complement
// by comparing the top chunk signed and all lower chunks unsigned.
module serial_cascade_comp #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] ain,
  input  logic [N-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         qL,
  output logic         qE,
  output logic         qG
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic [2:0]      lge_q, lge_d;     // {L, E, G}; 000 means no result yet
  logic [N-1:0]    a_q, b_q;
  logic            accept;

  logic [N-1:0]     a_sh, b_sh;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK-1:0] a_key, b_key;
  logic             chunk_lt, chunk_gt;

`ifdef SERCMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [CHUNK-1:0] SIGN_MSK = CHUNK'(1) << (CHUNK - 1);
  logic is_top;
`endif

  // Select the chunk under test and form its ordering keys.
  always_comb begin
    a_sh    = a_q >> (CHUNK * int'(idx_q));
    b_sh    = b_q >> (CHUNK * int'(idx_q));
    a_chunk = a_sh[CHUNK-1:0];
    b_chunk = b_sh[CHUNK-1:0];
`ifdef SERCMP_SIGNED_EN
    is_top  = (idx_q == IDX_TOP);
    a_key   = is_top ? (a_chunk ^ SIGN_MSK) : a_chunk;
    b_key   = is_top ? (b_chunk ^ SIGN_MSK) : b_chunk;
`else
    a_key   = a_chunk;
    b_key   = b_chunk;
`endif
    chunk_lt = (a_key < b_key);
    chunk_gt = (a_key > b_key);
  end

  // Next-state logic: accept in IDLE, decide or step down in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    lge_d   = lge_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = IDX_TOP;
          lge_d   = 3'b000;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (chunk_lt) begin
          lge_d   = 3'b100;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (chunk_gt) begin
          lge_d   = 3'b001;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          lge_d   = 3'b010;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with asynchronous reset; reset aborts any run silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      lge_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      lge_q   <= lge_d;
    end
  end

  // Operand capture; later input changes cannot disturb a running compare.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= ain;
      b_q <= bin;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign qL   = lge_q[2];
  assign qE   = lge_q[1];
  assign qG   = lge_q[0];

endmodule

// File: tb/tb_serial_cascade_comp.sv
// Scoreboard bench for serial_cascade_comp (N=16, CHUNK=4).
module tb_serial_cascade_comp;

  localparam int N      = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = N / CHUNK;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] ain = '0;
  logic [N-1:0] bin = '0;
  logic         busy, done, qL, qE, qG;

  serial_cascade_comp #(.N(N), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ain(ain), .bin(bin),
    .busy(busy), .done(done), .qL(qL), .qE(qE), .qG(qG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] lge;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: whole-operand comparison; latency = position of the most
  // significant differing chunk counted from the top, or NCHUNK if equal.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc);
    exp_t e;
    logic lt, gt;
`ifdef SERCMP_SIGNED_EN
    lt = $signed(a) < $signed(b);
    gt = $signed(a) > $signed(b);
`else
    lt = a < b;
    gt = a > b;
`endif
    e.lge = {lt, !lt && !gt, gt};
    e.acc = acc;
    e.lat = NCHUNK;
    for (int k = NCHUNK - 1; k >= 0; k--) begin
      if (((a >> (k * CHUNK)) & 16'hF) != ((b >> (k * CHUNK)) & 16'hF)) begin
        e.lat = NCHUNK - k;
        break;
      end
    end
    model = e;
  endfunction

  // Monitor: pops an expectation whenever done is presented.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_lge", {29'd0, qL, qE, qG}, {29'd0, e.lge});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    prev_done <= done;
  end

  // Issue one accepted start at a negedge; returns at the following negedge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("issue_wait_timeout", 32'd1, 32'd0);
    ain   = a;
    bin   = b;
    start = 1'b1;
    exp_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    ain   = $urandom;
    bin   = $urandom;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    exp_t e_sgn;

    // Reset state, held with start low.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {27'd0, busy, done, qL, qE, qG}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outs", {27'd0, busy, done, qL, qE, qG}, 32'd0);

    // Full-width walk: differs only in the lowest chunk.
    issue(16'h1234, 16'h1235);
    chk("busy_running", {31'd0, busy}, 32'd1);
    chk("flags_clear_running", {29'd0, qL, qE, qG}, 32'd0);
    wait_done();
    @(negedge clk);

    // Top-chunk decision; signedness decides direction.
    issue(16'h9000, 16'h1000);
    e_sgn = model(16'h9000, 16'h1000, 0);
    wait_done();
    chk("sign_case_lge", {29'd0, qL, qE, qG}, {29'd0, e_sgn.lge});
    @(negedge clk);

    // Equal operands: flags hold through idle cycles.
    issue(16'hABCD, 16'hABCD);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("eq_hold", {28'd0, busy, qL, qE, qG}, 32'b0010);
    end

    // Start during RUN is ignored; operands stay as captured.
    issue(16'h5555, 16'h5556);
    ain = 16'h0000; bin = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Back-to-back start in the done cycle: flags clear next cycle.
    issue(16'h0F00, 16'h0E00);
    chk("b2b_flags_clear", {28'd0, busy, qL, qE, qG}, 32'b1000);
    wait_done();
    @(negedge clk);

    // Reset mid-run after edge 2: no done, outputs return to reset values.
    issue(16'h4444, 16'h4444);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {27'd0, busy, done, qL, qE, qG}, 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("abort_hold", {27'd0, busy, done, qL, qE, qG}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h7000, 16'h7001);
    wait_done();
    @(negedge clk);

    // Randomized traffic with varied gaps, including back-to-back starts.
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      b = a;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b[($urandom_range(0, NCHUNK - 1)) * CHUNK +: CHUNK] = $urandom;
        2: b = a;
        default: b[$urandom_range(0, N - 1)] = ~a[$urandom_range(0, N - 1)];
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [N-1:0] s;
        s = a; a = b; b = s;
      end
      issue(a, b);
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
      end else begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end

    drain();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
